// File: rtl/fighter_fsm_pkg.sv
// Shared fighter definitions: state encodings and datapath widths used by the FSM,
// the renderer and the sprite selector.
package fighter_pkg;

  localparam int STATE_W = 4;
  localparam int X_W     = 10;
  localparam int FC_W    = 5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_LEFT   = 4'd1,
    S_RIGHT  = 4'd2,
    S_A1_S   = 4'd3,
    S_A1_A   = 4'd4,
    S_A1_R   = 4'd5,
    S_A2_S   = 4'd6,
    S_A2_A   = 4'd7,
    S_A2_R   = 4'd8,
    S_DAMAGE = 4'd9,
    S_BLOCK  = 4'd10
  } state_t;

  // A frame count must fit the counter and be at least one frame long.
  function automatic bit cnt_ok(input int v);
    return (v >= 1) && (v <= (1 << FC_W) - 1);
  endfunction

endpackage

// File: rtl/fighter_fsm_if.sv
// Per-player fighter bus: button/hit inputs in, state, position and hitbox out.
interface fighter_fsm_if;
  import fighter_pkg::*;

  logic              left_button;
  logic              right_button;
  logic              attack_button;
  logic              hit_in;
  logic [X_W-1:0]    opp_x;
  logic [STATE_W-1:0] state;
  logic [X_W-1:0]    char_x;
  logic [FC_W-1:0]   frame_cnt;
  logic              hitbox_active;
  logic [X_W-1:0]    hitbox_lo;
  logic [X_W-1:0]    hitbox_hi;
  logic              hit_taken;
  logic              blocked;

  modport master (
    input  left_button, right_button, attack_button, hit_in, opp_x,
    output state, char_x, frame_cnt, hitbox_active, hitbox_lo, hitbox_hi,
           hit_taken, blocked
  );

  modport slave (
    output left_button, right_button, attack_button, hit_in, opp_x,
    input  state, char_x, frame_cnt, hitbox_active, hitbox_lo, hitbox_hi,
           hit_taken, blocked
  );

endinterface

// File: rtl/fighter_fsm_frame_timer.sv
// Frames-in-state counter; done flags the last frame of a state of length i_len.
module frame_timer
  import fighter_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  input  logic [FC_W-1:0] i_len,
  output logic [FC_W-1:0] o_count,
  output logic            o_done
);

  logic [FC_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == i_len - 1'b1);

endmodule

// File: rtl/fighter_fsm.sv
// One fighter: movement, two attacks with frame data, hit/block reactions,
// wall and opponent clamping, and registered hitbox generation.
module fighter_fsm
  import fighter_pkg::*;
#(
  parameter bit FACING_RIGHT = 1'b1,
  parameter int START_X      = 100,
  parameter int CHAR_WIDTH   = 128,
  parameter int SCREEN_WIDTH = 640,
  parameter int FWD_SPEED    = 3,
  parameter int BACK_SPEED   = 2,
  parameter int A1_STARTUP   = 6,
  parameter int A1_ACTIVE    = 2,
  parameter int A1_RECOVERY  = 16,
  parameter int A2_STARTUP   = 5,
  parameter int A2_ACTIVE    = 3,
  parameter int A2_RECOVERY  = 15,
  parameter int HITSTUN      = 16,
  parameter int BLOCKSTUN    = 10,
  parameter int KNOCKBACK    = 16,
  parameter int BLOCK_PUSH   = 8,
  parameter int A1_REACH     = 40,
  parameter int A2_REACH     = 56
) (
  input logic          clk_game,
  input logic          reset,
  fighter_fsm_if.master bus
);

  // Two spare bits keep opp_x + CHAR_WIDTH and x - push from wrapping.
  localparam int SX_W  = X_W + 2;
  localparam int MAX_X = SCREEN_WIDTH - CHAR_WIDTH;
  typedef logic signed [SX_W-1:0] sx_t;

  localparam state_t FWD_ST  = FACING_RIGHT ? S_RIGHT : S_LEFT;
  localparam state_t BACK_ST = FACING_RIGHT ? S_LEFT : S_RIGHT;

  if (!(cnt_ok(A1_STARTUP) && cnt_ok(A1_ACTIVE) && cnt_ok(A1_RECOVERY) &&
        cnt_ok(A2_STARTUP) && cnt_ok(A2_ACTIVE) && cnt_ok(A2_RECOVERY) &&
        cnt_ok(HITSTUN) && cnt_ok(BLOCKSTUN))) begin : g_bad_count
    $error("fighter_fsm: every frame count parameter must be in 1..31");
  end

  state_t          r_state, w_next;
  logic [X_W-1:0]  r_x, w_x_next;
  logic            r_hb_act, w_hb_act;
  logic [X_W-1:0]  r_hb_lo, r_hb_hi, w_hb_lo, w_hb_hi, w_reach;
  logic            r_hit_taken, r_blocked;
  logic            w_hit, w_hit_taken, w_blocked, w_fwd;
  logic [FC_W-1:0] w_len, w_count;
  logic            w_clear, w_done;
  sx_t             w_delta, w_cand, w_opp_hi, w_opp_lo;

  frame_timer u_timer (
    .i_clk   (clk_game),
    .i_rst   (reset),
    .i_clear (w_clear),
    .i_len   (w_len),
    .o_count (w_count),
    .o_done  (w_done)
  );

  always_comb begin
    w_len = FC_W'(1);
    case (r_state)
      S_A1_S:   w_len = FC_W'(A1_STARTUP);
      S_A1_A:   w_len = FC_W'(A1_ACTIVE);
      S_A1_R:   w_len = FC_W'(A1_RECOVERY);
      S_A2_S:   w_len = FC_W'(A2_STARTUP);
      S_A2_A:   w_len = FC_W'(A2_ACTIVE);
      S_A2_R:   w_len = FC_W'(A2_RECOVERY);
      S_DAMAGE: w_len = FC_W'(HITSTUN);
      S_BLOCK:  w_len = FC_W'(BLOCKSTUN);
      default:  w_len = FC_W'(1);
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_hit_taken = 1'b0;
    w_blocked   = 1'b0;
    w_hit       = bus.hit_in && (r_state != S_DAMAGE) && (r_state != S_BLOCK);
    if (w_hit) begin
      if (r_state == BACK_ST) begin
        w_next    = S_BLOCK;
        w_blocked = 1'b1;
      end else begin
        w_next      = S_DAMAGE;
        w_hit_taken = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.attack_button)     w_next = S_A1_S;
          else if (bus.left_button)  w_next = S_LEFT;
          else if (bus.right_button) w_next = S_RIGHT;
        end
        S_LEFT: begin
          if (bus.attack_button)     w_next = (FWD_ST == S_LEFT) ? S_A2_S : S_A1_S;
          else if (!bus.left_button) w_next = bus.right_button ? S_RIGHT : S_IDLE;
        end
        S_RIGHT: begin
          if (bus.attack_button)      w_next = (FWD_ST == S_RIGHT) ? S_A2_S : S_A1_S;
          else if (!bus.right_button) w_next = bus.left_button ? S_LEFT : S_IDLE;
        end
        S_A1_S:   if (w_done) w_next = S_A1_A;
        S_A1_A:   if (w_done) w_next = S_A1_R;
        S_A1_R:   if (w_done) w_next = S_IDLE;
        S_A2_S:   if (w_done) w_next = S_A2_A;
        S_A2_A:   if (w_done) w_next = S_A2_R;
        S_A2_R:   if (w_done) w_next = S_IDLE;
        S_DAMAGE: if (w_done) w_next = S_IDLE;
        S_BLOCK:  if (w_done) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  assign w_clear = (w_next != r_state) || (r_state inside {S_IDLE, S_LEFT, S_RIGHT});

  assign w_opp_hi = $signed({2'b00, bus.opp_x}) - sx_t'(CHAR_WIDTH);
  assign w_opp_lo = $signed({2'b00, bus.opp_x}) + sx_t'(CHAR_WIDTH);

  always_comb begin
    w_fwd   = 1'b0;
    w_delta = '0;
    if (w_hit) begin
      w_delta = (r_state == BACK_ST) ? sx_t'(BLOCK_PUSH) : sx_t'(KNOCKBACK);
      if (FACING_RIGHT) w_delta = -w_delta;
    end else if (r_state == FWD_ST) begin
      w_fwd   = 1'b1;
      w_delta = FACING_RIGHT ? sx_t'(FWD_SPEED) : -sx_t'(FWD_SPEED);
    end else if (r_state == BACK_ST) begin
      w_delta = FACING_RIGHT ? -sx_t'(BACK_SPEED) : sx_t'(BACK_SPEED);
    end
    w_cand = $signed({2'b00, r_x}) + w_delta;
    if (w_fwd) begin
      if (FACING_RIGHT) begin
        if (w_cand > w_opp_hi) w_cand = w_opp_hi;
      end else begin
        if (w_cand < w_opp_lo) w_cand = w_opp_lo;
      end
    end
    if (w_cand < 0)                   w_x_next = '0;
    else if (w_cand > sx_t'(MAX_X))   w_x_next = X_W'(MAX_X);
    else                              w_x_next = w_cand[X_W-1:0];
  end

  // Hitbox is derived from next state/position so it lines up with the registered state.
  always_comb begin
    w_hb_act = (w_next == S_A1_A) || (w_next == S_A2_A);
    w_reach  = (w_next == S_A1_A) ? X_W'(A1_REACH) : X_W'(A2_REACH);
    w_hb_lo  = '0;
    w_hb_hi  = '0;
    if (w_hb_act) begin
      if (FACING_RIGHT) begin
        w_hb_lo = w_x_next + X_W'(CHAR_WIDTH);
        w_hb_hi = w_hb_lo + w_reach;
      end else begin
        w_hb_hi = w_x_next;
        w_hb_lo = (w_x_next >= w_reach) ? w_x_next - w_reach : '0;
      end
    end
  end

  always_ff @(posedge clk_game) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= X_W'(START_X);
      r_hb_act    <= 1'b0;
      r_hb_lo     <= '0;
      r_hb_hi     <= '0;
      r_hit_taken <= 1'b0;
      r_blocked   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_x         <= w_x_next;
      r_hb_act    <= w_hb_act;
      r_hb_lo     <= w_hb_lo;
      r_hb_hi     <= w_hb_hi;
      r_hit_taken <= w_hit_taken;
      r_blocked   <= w_blocked;
    end
  end

  assign bus.state         = r_state;
  assign bus.char_x        = r_x;
  assign bus.frame_cnt     = w_count;
  assign bus.hitbox_active = r_hb_act;
  assign bus.hitbox_lo     = r_hb_lo;
  assign bus.hitbox_hi     = r_hb_hi;
  assign bus.hit_taken     = r_hit_taken;
  assign bus.blocked       = r_blocked;

endmodule

// File: tb/tb_fighter_fsm.sv
// Directed checks of fighter_fsm: walk, attacks, damage, block, clamps and reset.
module tb_fighter_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fighter_fsm_if b0 ();
  fighter_fsm_if b1 ();
  fighter_fsm_if b2 ();

  fighter_fsm #(.FACING_RIGHT(1'b1), .START_X(100)) dut0 (.clk_game(clk), .reset(rst), .bus(b0));
  fighter_fsm #(.FACING_RIGHT(1'b1), .START_X(1))   dut1 (.clk_game(clk), .reset(rst), .bus(b1));
  fighter_fsm #(.FACING_RIGHT(1'b0), .START_X(400)) dut2 (.clk_game(clk), .reset(rst), .bus(b2));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input int st, input int x, input int fc);
    check({tag, ".state"}, int'(b0.state), st);
    check({tag, ".x"}, int'(b0.char_x), x);
    check({tag, ".fc"}, int'(b0.frame_cnt), fc);
  endtask

  task automatic chk_hb0(input string tag, input int act, input int lo, input int hi);
    check({tag, ".hb_act"}, int'(b0.hitbox_active), act);
    check({tag, ".hb_lo"}, int'(b0.hitbox_lo), lo);
    check({tag, ".hb_hi"}, int'(b0.hitbox_hi), hi);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    {b0.left_button, b0.right_button, b0.attack_button, b0.hit_in} = '0;
    {b1.left_button, b1.right_button, b1.attack_button, b1.hit_in} = '0;
    {b2.left_button, b2.right_button, b2.attack_button, b2.hit_in} = '0;
    b0.opp_x = 10'd600;
    b1.opp_x = 10'd600;
    b2.opp_x = 10'd0;

    // Reset values
    tick();
    chk0("rst", 0, 100, 0);
    chk_hb0("rst", 0, 0, 0);
    check("rst.hit_taken", int'(b0.hit_taken), 0);
    check("rst.blocked", int'(b0.blocked), 0);
    check("rst.x1", int'(b1.char_x), 1);
    check("rst.x2", int'(b2.char_x), 400);
    rst = 1'b0;

    // Walk forward: entry edge does not move, then 3 px per edge, exit edge moves too
    b0.right_button = 1'b1;
    tick();
    chk0("walk0", 2, 100, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk0("walk", 2, 100 + 3 * i, 0);
    end
    b0.right_button = 1'b0;
    tick();
    chk0("walk_exit", 0, 115, 0);
    do_reset();

    // Standing attack, attack held during startup is ignored
    b0.attack_button = 1'b1;
    tick();
    chk0("a1s0", 3, 100, 0);
    chk_hb0("a1s0", 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk0("a1s", 3, 100, i);
    end
    b0.attack_button = 1'b0;
    tick();
    chk0("a1a0", 4, 100, 0);
    chk_hb0("a1a0", 1, 228, 268);
    tick();
    chk0("a1a1", 4, 100, 1);
    chk_hb0("a1a1", 1, 228, 268);
    tick();
    chk0("a1r0", 5, 100, 0);
    chk_hb0("a1r0", 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("a1r.state", int'(b0.state), 5);
    end
    tick();
    chk0("a1_end", 0, 100, 0);

    // Damage: further hits and buttons ignored through the whole reaction
    b0.hit_in = 1'b1;
    tick();
    chk0("dmg0", 9, 84, 0);
    check("dmg0.hit_taken", int'(b0.hit_taken), 1);
    b0.left_button = 1'b1;
    b0.attack_button = 1'b1;
    tick();
    chk0("dmg1", 9, 84, 1);
    check("dmg1.hit_taken", int'(b0.hit_taken), 0);
    for (int i = 2; i <= 15; i++) begin
      tick();
      check("dmg.state", int'(b0.state), 9);
    end
    tick();
    chk0("dmg_end", 0, 84, 0);
    b0.hit_in = 1'b0;
    b0.attack_button = 1'b0;

    // Block while walking backward
    tick();
    chk0("back0", 1, 84, 0);
    tick();
    chk0("back1", 1, 82, 0);
    b0.hit_in = 1'b1;
    tick();
    chk0("blk0", 10, 74, 0);
    check("blk0.blocked", int'(b0.blocked), 1);
    check("blk0.hit_taken", int'(b0.hit_taken), 0);
    b0.hit_in = 1'b0;
    b0.left_button = 1'b0;
    tick();
    check("blk1.blocked", int'(b0.blocked), 0);
    for (int i = 2; i <= 9; i++) tick();
    chk0("blk9", 10, 74, 9);
    tick();
    chk0("blk_end", 0, 74, 0);

    // Hit on the edge startup would have exited preempts the attack
    b0.attack_button = 1'b1;
    tick();
    b0.attack_button = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk0("pre_s5", 3, 74, 5);
    b0.hit_in = 1'b1;
    tick();
    b0.hit_in = 1'b0;
    chk0("preempt", 9, 58, 0);
    chk_hb0("preempt", 0, 0, 0);
    do_reset();

    // Opponent clamp: opp at 240 limits x to 112
    b0.opp_x = 10'd240;
    b0.right_button = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) tick();
    chk0("opp_clamp", 2, 112, 0);
    b0.right_button = 1'b0;
    tick();
    chk0("opp_exit", 0, 112, 0);

    // Reset during the active window wins over hit and buttons
    b0.attack_button = 1'b1;
    tick();
    b0.attack_button = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    chk0("mid_a1a", 4, 112, 0);
    chk_hb0("mid_a1a", 1, 240, 280);
    rst = 1'b1;
    b0.hit_in = 1'b1;
    b0.attack_button = 1'b1;
    tick();
    chk0("mid_rst", 0, 100, 0);
    chk_hb0("mid_rst", 0, 0, 0);
    check("mid_rst.hit_taken", int'(b0.hit_taken), 0);
    rst = 1'b0;
    b0.hit_in = 1'b0;
    b0.attack_button = 1'b0;

    // Left wall clamp (dut1) and facing-left forward walk into moving attack (dut2)
    b1.left_button = 1'b1;
    b2.left_button = 1'b1;
    tick();
    check("wall0.x", int'(b1.char_x), 1);
    check("fl0.state", int'(b2.state), 1);
    tick();
    check("wall1.x", int'(b1.char_x), 0);
    check("fl1.x", int'(b2.char_x), 397);
    tick();
    check("wall2.x", int'(b1.char_x), 0);
    check("fl2.x", int'(b2.char_x), 394);
    b2.attack_button = 1'b1;
    tick();
    check("wall3.x", int'(b1.char_x), 0);
    check("fl_a2s.state", int'(b2.state), 6);
    check("fl_a2s.x", int'(b2.char_x), 391);
    b2.attack_button = 1'b0;
    b2.left_button = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    check("fl_a2s4.fc", int'(b2.frame_cnt), 4);
    check("fl_a2s4.hb", int'(b2.hitbox_active), 0);
    tick();
    check("fl_a2a.state", int'(b2.state), 7);
    check("fl_a2a.hb_act", int'(b2.hitbox_active), 1);
    check("fl_a2a.hb_lo", int'(b2.hitbox_lo), 335);
    check("fl_a2a.hb_hi", int'(b2.hitbox_hi), 391);
    check("wall_hold.x", int'(b1.char_x), 0);
    check("wall_hold.state", int'(b1.state), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
